// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init sequencer and periodic refresh scheduler.
// Define REFRESH_QUEUE_EN to allow up to 7 owed refreshes instead of 1.
module sdram_init_refresh #(
    parameter int          INIT_WAIT        = 2500,
    parameter int          INIT_REFRESHES   = 2,
    parameter int          REFRESH_INTERVAL = 195,
    parameter int          TRP              = 1,
    parameter int          TRFC             = 2,
    parameter int          TMRD             = 2,
    parameter logic [12:0] MODE_REG         = 13'h020
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        idle,
    output logic        init_done,
    output logic        ref_req,
    output logic        owns_bus,
    output logic        ref_overflow,
    output logic        CKE,
    output logic [1:0]  CS_n,
    output logic        RAS_n,
    output logic        CAS_n,
    output logic        WE_n,
    output logic [1:0]  BA,
    output logic [12:0] MA
);

`ifdef REFRESH_QUEUE_EN
    localparam int PW = 3;
`else
    localparam int PW = 1;
`endif
    localparam int CW = 16;
    localparam int TW = $clog2(REFRESH_INTERVAL + 1);
    localparam int RW = $clog2(INIT_REFRESHES + 1);

    localparam logic [PW-1:0] P_MAX = '1;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_PRECHARGE,
        S_WAIT_TRP,
        S_INIT_REF,
        S_WAIT_TRFC,
        S_LOAD_MODE,
        S_WAIT_TMRD,
        S_IDLE,
        S_REFRESH,
        S_WAIT_RFC
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] pending;
    logic [PW-1:0] pending_nxt;
    logic          ovf_set;
    logic          tick;
    logic          ref_go;

    assign tick   = init_done && (tcnt == '0);
    assign ref_go = (state == S_IDLE) && idle && (pending != '0);

    // A tick and a refresh entry on the same edge cancel out.
    always_comb begin
        pending_nxt = pending;
        ovf_set     = 1'b0;
        if (tick && !ref_go) begin
            if (pending == P_MAX)
                ovf_set = 1'b1;
            else
                pending_nxt = pending + 1'b1;
        end else if (!tick && ref_go) begin
            pending_nxt = pending - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            tcnt         <= TW'(REFRESH_INTERVAL - 1);
            pending      <= '0;
            ref_req      <= 1'b0;
            ref_overflow <= 1'b0;
        end else begin
            if (init_done) begin
                if (tcnt == '0)
                    tcnt <= TW'(REFRESH_INTERVAL - 1);
                else
                    tcnt <= tcnt - 1'b1;
            end
            pending      <= pending_nxt;
            ref_req      <= (pending_nxt != '0);
            ref_overflow <= ref_overflow | ovf_set;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state               <= S_INIT_WAIT;
            cnt                 <= '0;
            rcnt                <= '0;
            CKE                 <= 1'b0;
            CS_n                <= 2'b11;
            {RAS_n, CAS_n, WE_n} <= C_NOP;
            BA                  <= 2'b00;
            MA                  <= '0;
            owns_bus            <= 1'b1;
            init_done           <= 1'b0;
        end else begin
            CKE                 <= 1'b1;
            CS_n                <= 2'b00;
            {RAS_n, CAS_n, WE_n} <= C_NOP;
            BA                  <= 2'b00;
            MA                  <= '0;
            unique case (state)
                S_INIT_WAIT: begin
                    if (cnt == CW'(INIT_WAIT)) begin
                        state                <= S_PRECHARGE;
                        {RAS_n, CAS_n, WE_n} <= C_PRE;
                        MA[10]               <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PRECHARGE: begin
                    state <= S_WAIT_TRP;
                    cnt   <= CW'(TRP - 1);
                end
                S_WAIT_TRP: begin
                    if (cnt == '0) begin
                        state                <= S_INIT_REF;
                        rcnt                 <= RW'(1);
                        {RAS_n, CAS_n, WE_n} <= C_REF;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_INIT_REF: begin
                    state <= S_WAIT_TRFC;
                    cnt   <= CW'(TRFC - 1);
                end
                S_WAIT_TRFC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rcnt == RW'(INIT_REFRESHES)) begin
                        state                <= S_LOAD_MODE;
                        {RAS_n, CAS_n, WE_n} <= C_LMR;
                        MA                   <= MODE_REG;
                    end else begin
                        state                <= S_INIT_REF;
                        rcnt                 <= rcnt + 1'b1;
                        {RAS_n, CAS_n, WE_n} <= C_REF;
                    end
                end
                S_LOAD_MODE: begin
                    state <= S_WAIT_TMRD;
                    cnt   <= CW'(TMRD - 1);
                end
                S_WAIT_TMRD: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        CS_n      <= 2'b11;
                        owns_bus  <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (ref_go) begin
                        state                <= S_REFRESH;
                        {RAS_n, CAS_n, WE_n} <= C_REF;
                        owns_bus             <= 1'b1;
                    end else begin
                        CS_n <= 2'b11;
                    end
                end
                S_REFRESH: begin
                    state <= S_WAIT_RFC;
                    cnt   <= CW'(TRFC - 1);
                end
                S_WAIT_RFC: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        CS_n     <= 2'b11;
                        owns_bus <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed testbench for sdram_init_refresh.
// Builds with or without REFRESH_QUEUE_EN.
module tb_sdram_init_refresh;

    localparam int INIT_WAIT        = 10;
    localparam int INIT_REFRESHES   = 2;
    localparam int REFRESH_INTERVAL = 20;
    localparam int TRP              = 1;
    localparam int TRFC             = 2;
    localparam int TMRD             = 2;

`ifdef REFRESH_QUEUE_EN
    localparam int EXP_Q_ARS   = 5;
    localparam bit EXP_Q_OVF   = 1'b0;
    localparam int OVF_EDGE    = 181;
    localparam int EXP_SAT_ARS = 8;
`else
    localparam int EXP_Q_ARS   = 1;
    localparam bit EXP_Q_OVF   = 1'b1;
    localparam int OVF_EDGE    = 61;
    localparam int EXP_SAT_ARS = 2;
`endif

    localparam logic [7:0] V_NOP  = 8'b1_00_111_1_0;
    localparam logic [7:0] V_PRE  = 8'b1_00_010_1_0;
    localparam logic [7:0] V_AR   = 8'b1_00_001_1_0;
    localparam logic [7:0] V_LMR  = 8'b1_00_000_1_0;
    localparam logic [7:0] V_DONE = 8'b1_11_111_0_1;
    localparam logic [24:0] V_RST = {1'b0, 2'b11, 3'b111, 2'b00, 13'h0, 4'b0100};

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        idle;
    logic        init_done, ref_req, owns_bus, ref_overflow;
    logic        CKE, RAS_n, CAS_n, WE_n;
    logic [1:0]  CS_n, BA;
    logic [12:0] MA;

    int vectors = 0;
    int errors  = 0;
    int cyc;

    sdram_init_refresh #(
        .INIT_WAIT(INIT_WAIT),
        .INIT_REFRESHES(INIT_REFRESHES),
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .TRP(TRP),
        .TRFC(TRFC),
        .TMRD(TMRD),
        .MODE_REG(13'h020)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .idle(idle),
        .init_done(init_done),
        .ref_req(ref_req),
        .owns_bus(owns_bus),
        .ref_overflow(ref_overflow),
        .CKE(CKE),
        .CS_n(CS_n),
        .RAS_n(RAS_n),
        .CAS_n(CAS_n),
        .WE_n(WE_n),
        .BA(BA),
        .MA(MA)
    );

    always #5 CLK = ~CLK;

    // Edge index: 0 is the first rising edge after reset release.
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    function automatic logic is_ar();
        return (CS_n == 2'b00) && ({RAS_n, CAS_n, WE_n} == 3'b001);
    endfunction

    task automatic goto(input int k);
        for (int i = 0; i < 2000 && cyc < k; i++) @(negedge CLK);
        vectors++;
        if (cyc != k) begin
            errors++;
            $display("FAIL goto: at edge %0d, required edge %0d", cyc, k);
        end
    endtask

    task automatic do_reset(input logic idle_v);
        @(negedge CLK);
        RST_n = 1'b0;
        idle  = idle_v;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [24:0] got;
        got = {CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MA,
               init_done, owns_bus, ref_req, ref_overflow};
        vectors++;
        if (got !== V_RST) begin
            errors++;
            $display("FAIL reset_vals: got %h required %h", got, V_RST);
        end
    endtask

    task automatic test_init;
        logic [7:0] got, exp;
        for (int k = 0; k <= 21; k++) begin
            goto(k);
            got = {CKE, CS_n, RAS_n, CAS_n, WE_n, owns_bus, init_done};
            if (k == 10)                 exp = V_PRE;
            else if (k == 12 || k == 15) exp = V_AR;
            else if (k == 18)            exp = V_LMR;
            else if (k == 21)            exp = V_DONE;
            else                         exp = V_NOP;
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL init_cmd[%0d]: got %b required %b", k, got, exp);
            end
            if (k == 10) begin
                vectors++;
                if (MA[10] !== 1'b1) begin
                    errors++;
                    $display("FAIL pre_ma10: got %b required 1", MA[10]);
                end
            end
            if (k == 18) begin
                vectors++;
                if ({BA, MA} !== {2'b00, 13'h020}) begin
                    errors++;
                    $display("FAIL lmr_addr: got %h required %h", {BA, MA}, {2'b00, 13'h020});
                end
            end
        end
    endtask

    task automatic test_periodic;
        logic [2:0] got, exp;
        for (int k = 22; k <= 105; k++) begin
            goto(k);
            exp[2] = (k >= 41) && ((k - 41) % 20 == 0);
            exp[1] = (k >= 42) && ((k - 42) % 20 == 0);
            exp[0] = (k >= 42) && ((k - 42) % 20 < 3);
            got = {ref_req, is_ar(), owns_bus};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL periodic[%0d]: req/ar/own got %b required %b", k, got, exp);
            end
        end
        vectors++;
        if (ref_overflow !== 1'b0) begin
            errors++;
            $display("FAIL periodic_ovf: got %b required 0", ref_overflow);
        end
    endtask

    task automatic test_reset_mid_refresh;
        logic [24:0] got;
        goto(123);
        vectors++;
        if ({owns_bus, CS_n, RAS_n, CAS_n, WE_n} !== 6'b1_00_111) begin
            errors++;
            $display("FAIL wait_rfc: got %b required 100111",
                     {owns_bus, CS_n, RAS_n, CAS_n, WE_n});
        end
        #2 RST_n = 1'b0;
        #1;
        got = {CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MA,
               init_done, owns_bus, ref_req, ref_overflow};
        vectors++;
        if (got !== V_RST) begin
            errors++;
            $display("FAIL midref_reset: got %h required %h", got, V_RST);
        end
        idle = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        test_init();
    endtask

    task automatic test_queue;
        int n_ar;
        int first;
        goto(121);
        vectors++;
        if ({ref_req, ref_overflow} !== {1'b1, EXP_Q_OVF}) begin
            errors++;
            $display("FAIL queue_state: req/ovf got %b required %b",
                     {ref_req, ref_overflow}, {1'b1, EXP_Q_OVF});
        end
        idle  = 1'b1;
        n_ar  = 0;
        first = -1;
        for (int k = 122; k <= 140; k++) begin
            goto(k);
            if (is_ar()) begin
                if (first < 0) first = k;
                vectors++;
                if ((k - 122) % 4 != 0) begin
                    errors++;
                    $display("FAIL queue_spacing: refresh at edge %0d required 122+4n", k);
                end
                n_ar++;
            end
        end
        vectors++;
        if (n_ar != EXP_Q_ARS || first != 122) begin
            errors++;
            $display("FAIL queue_drain: got %0d refreshes from %0d required %0d from 122",
                     n_ar, first, EXP_Q_ARS);
        end
    endtask

    task automatic test_coincide;
        do_reset(1'b0);
        test_init();
        goto(60);
        vectors++;
        if (ref_req !== 1'b1) begin
            errors++;
            $display("FAIL coin_pre: ref_req got %b required 1", ref_req);
        end
        idle = 1'b1;
        goto(61);
        vectors++;
        if ({is_ar(), ref_req, ref_overflow} !== 3'b110) begin
            errors++;
            $display("FAIL coin_entry: ar/req/ovf got %b required 110",
                     {is_ar(), ref_req, ref_overflow});
        end
        goto(64);
        vectors++;
        if ({is_ar(), owns_bus, ref_req} !== 3'b001) begin
            errors++;
            $display("FAIL coin_idle: ar/own/req got %b required 001",
                     {is_ar(), owns_bus, ref_req});
        end
        goto(65);
        vectors++;
        if ({is_ar(), ref_req} !== 2'b10) begin
            errors++;
            $display("FAIL coin_second: ar/req got %b required 10", {is_ar(), ref_req});
        end
    endtask

    task automatic test_back_to_back;
        int n_ar;
        do_reset(1'b0);
        test_init();
        goto(OVF_EDGE - 1);
        vectors++;
        if (ref_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before: got %b required 0", ref_overflow);
        end
        goto(OVF_EDGE);
        vectors++;
        if (ref_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got %b required 1", ref_overflow);
        end
        goto(221);
        idle = 1'b1;
        n_ar = 0;
        for (int k = 222; k <= 259; k++) begin
            goto(k);
            if (is_ar()) n_ar++;
        end
        vectors++;
        if (n_ar != EXP_SAT_ARS || ref_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_drain: got %0d refreshes ovf %b required %0d ovf 1",
                     n_ar, ref_overflow, EXP_SAT_ARS);
        end
    endtask

    initial begin
        RST_n = 1'b0;
        idle  = 1'b1;
        repeat (3) @(negedge CLK);
        test_reset();
        RST_n = 1'b1;
        test_init();
        test_periodic();
        test_reset_mid_refresh();
        test_queue();
        test_coincide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
